// File: rtl/screen_scanout.sv
// Raster scan-out of the SCREEN RAM region: one fetch per 16 pixels, bit 0 leftmost, one pixel per clock.
// Latency: all video outputs trail the counters by 2 clocks. No back-pressure: rd_data must arrive the cycle after rd_en.
module screen_scanout #(
    parameter int   H_ACTIVE = 512,
    parameter int   H_FRONT  = 16,
    parameter int   H_SYNC   = 96,
    parameter int   H_BACK   = 176,
    parameter int   V_ACTIVE = 256,
    parameter int   V_FRONT  = 122,
    parameter int   V_SYNC   = 2,
    parameter int   V_BACK   = 145,
    parameter logic SYNC_POL = 1'b0
) (
    input  logic        clk,
    input  logic        reset,
    output logic        rd_en,
    output logic [12:0] rd_addr,
    input  logic [15:0] rd_data,
    output logic        pixel,
    output logic        hsync,
    output logic        vsync,
    output logic        de,
    output logic        frame_start
);
    localparam int H_TOTAL = H_ACTIVE + H_FRONT + H_SYNC + H_BACK;
    localparam int V_TOTAL = V_ACTIVE + V_FRONT + V_SYNC + V_BACK;
    localparam int HW = $clog2(H_TOTAL + 1);
    localparam int VW = $clog2(V_TOTAL + 1);

    localparam logic [HW-1:0] H_LAST = HW'(H_TOTAL - 1);
    localparam logic [HW-1:0] H_ACT  = HW'(H_ACTIVE);
    localparam logic [HW-1:0] HS_BEG = HW'(H_ACTIVE + H_FRONT);
    localparam logic [HW-1:0] HS_END = HW'(H_ACTIVE + H_FRONT + H_SYNC);
    localparam logic [VW-1:0] V_LAST = VW'(V_TOTAL - 1);
    localparam logic [VW-1:0] V_ACT  = VW'(V_ACTIVE);
    localparam logic [VW-1:0] VS_BEG = VW'(V_ACTIVE + V_FRONT);
    localparam logic [VW-1:0] VS_END = VW'(V_ACTIVE + V_FRONT + V_SYNC);

    // S0: counters and fetch address
    logic [HW-1:0] hcount_q, hcount_d;
    logic [VW-1:0] vcount_q, vcount_d;
    logic [12:0]   addr_q, fetch_addr;
    logic          act0, hs0, vs0, fs0;

    // S1 / S2 pipeline
    logic          fetch_q, act1_q, hs1_q, vs1_q, fs1_q;
    logic          act2_q, hs2_q, vs2_q, fs2_q;
    logic [15:0]   shreg_q, shreg_d;

    always_comb begin
        hcount_d = hcount_q + 1'b1;
        vcount_d = vcount_q;
        if (hcount_q == H_LAST) begin
            hcount_d = '0;
            vcount_d = (vcount_q == V_LAST) ? '0 : vcount_q + 1'b1;
        end
    end

    assign act0       = (hcount_q < H_ACT) && (vcount_q < V_ACT);
    assign hs0        = ((hcount_q >= HS_BEG) && (hcount_q < HS_END)) ? SYNC_POL : ~SYNC_POL;
    assign vs0        = ((vcount_q >= VS_BEG) && (vcount_q < VS_END)) ? SYNC_POL : ~SYNC_POL;
    assign fs0        = (hcount_q == '0) && (vcount_q == '0);
    assign fetch_addr = 13'((32'(vcount_q) & 32'hFF) * 32 + (32'(hcount_q) >> 4));

    // Reset gates the request so a held reset never issues reads from the parked counters.
    assign rd_en   = act0 && (hcount_q[3:0] == 4'd0) && !reset;
    assign rd_addr = rd_en ? fetch_addr : addr_q;

    // A freshly fetched word replaces whatever is left; otherwise shift toward bit 0.
    assign shreg_d = fetch_q ? rd_data : {1'b0, shreg_q[15:1]};

    always_ff @(posedge clk) begin
        if (reset) begin
            hcount_q <= '0;
            vcount_q <= '0;
            addr_q   <= '0;
            fetch_q  <= 1'b0;
            act1_q   <= 1'b0;
            hs1_q    <= ~SYNC_POL;
            vs1_q    <= ~SYNC_POL;
            fs1_q    <= 1'b0;
            shreg_q  <= '0;
            act2_q   <= 1'b0;
            hs2_q    <= ~SYNC_POL;
            vs2_q    <= ~SYNC_POL;
            fs2_q    <= 1'b0;
        end else begin
            hcount_q <= hcount_d;
            vcount_q <= vcount_d;
            if (rd_en) begin
                addr_q <= fetch_addr;
            end
            fetch_q  <= rd_en;
            act1_q   <= act0;
            hs1_q    <= hs0;
            vs1_q    <= vs0;
            fs1_q    <= fs0;
            shreg_q  <= shreg_d;
            act2_q   <= act1_q;
            hs2_q    <= hs1_q;
            vs2_q    <= vs1_q;
            fs2_q    <= fs1_q;
        end
    end

    assign pixel       = shreg_q[0] & act2_q;
    assign de          = act2_q;
    assign hsync       = hs2_q;
    assign vsync       = vs2_q;
    assign frame_start = fs2_q;

endmodule

// File: tb/tb_screen_scanout.sv
// Bench for screen_scanout: raster model from cycle index plus directed literal checks.
// Vertical timing is shortened so whole frames fit in a short run; horizontal timing is default.
module tb_screen_scanout;
    localparam int H_ACT = 512, H_FP = 16, H_SY = 96, H_BK = 176;
    localparam int V_ACT = 6, V_FP = 3, V_SY = 2, V_BK = 3;
    localparam int H_TOT = H_ACT + H_FP + H_SY + H_BK;
    localparam int V_TOT = V_ACT + V_FP + V_SY + V_BK;

    logic        clk = 1'b0;
    logic        reset;
    logic        rd_en;
    logic [12:0] rd_addr;
    logic [15:0] rd_data;
    logic        pixel, hsync, vsync, de, frame_start;

    logic [15:0] mem [0:8191];
    int          t = 0;
    logic [12:0] hold = '0;
    bit          chk_en = 1'b0;
    int          n_chk = 0;
    int          n_fail = 0;

    screen_scanout #(
        .H_ACTIVE(H_ACT), .H_FRONT(H_FP), .H_SYNC(H_SY), .H_BACK(H_BK),
        .V_ACTIVE(V_ACT), .V_FRONT(V_FP), .V_SYNC(V_SY), .V_BACK(V_BK),
        .SYNC_POL(1'b0)
    ) dut (
        .clk(clk), .reset(reset), .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data),
        .pixel(pixel), .hsync(hsync), .vsync(vsync), .de(de), .frame_start(frame_start)
    );

    always #5 clk = ~clk;

    // Memory answers one cycle after a request; otherwise the bus carries junk.
    always @(posedge clk) rd_data <= rd_en ? mem[rd_addr] : 16'($urandom);

    function automatic bit act_f(input int h, input int v);
        return (h < H_ACT) && (v < V_ACT);
    endfunction

    function automatic bit fetch_f(input int c);
        int h, v;
        h = c % H_TOT;
        v = (c / H_TOT) % V_TOT;
        return act_f(h, v) && (h % 16 == 0);
    endfunction

    function automatic logic [12:0] addr_f(input int c);
        int h, v;
        h = c % H_TOT;
        v = (c / H_TOT) % V_TOT;
        return 13'(v * 32 + h / 16);
    endfunction

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            if (n_fail <= 40)
                $display("FAIL %s t=%0d got=%0h expected=%0h", nm, t, got, exp);
        end
    endtask

    // t = clocks since the last reset edge, i.e. the raster index the counters should hold.
    always @(posedge clk) begin
        if (reset) begin
            t    <= 0;
            hold <= '0;
        end else begin
            if (fetch_f(t)) hold <= addr_f(t);
            t <= t + 1;
        end
    end

    always @(negedge clk) begin : cmp
        int m, h, v;
        bit e_fetch, e_de, e_pix, e_hs, e_vs, e_fs;
        if (chk_en) begin
            e_fetch = !reset && fetch_f(t);
            chk("rd_en", 32'(rd_en), 32'(e_fetch));
            chk("rd_addr", 32'(rd_addr), 32'(e_fetch ? addr_f(t) : hold));
            e_de = 0; e_pix = 0; e_hs = 1; e_vs = 1; e_fs = 0;
            if (t >= 2) begin
                m = t - 2;
                h = m % H_TOT;
                v = (m / H_TOT) % V_TOT;
                e_de  = act_f(h, v);
                e_pix = e_de && mem[v * 32 + h / 16][h % 16];
                e_hs  = !((h >= H_ACT + H_FP) && (h < H_ACT + H_FP + H_SY));
                e_vs  = !((v >= V_ACT + V_FP) && (v < V_ACT + V_FP + V_SY));
                e_fs  = (h == 0) && (v == 0);
            end
            chk("pixel", 32'(pixel), 32'(e_pix));
            chk("de", 32'(de), 32'(e_de));
            chk("hsync", 32'(hsync), 32'(e_hs));
            chk("vsync", 32'(vsync), 32'(e_vs));
            chk("frame_start", 32'(frame_start), 32'(e_fs));
        end
    end

    task automatic wait_t(input int tgt);
        int n;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (t != tgt && n < 40000);
        if (t != tgt) chk("wait_t", 32'(t), 32'(tgt));
    endtask

    initial begin
        int hi_cnt, hi_last, hs_first, hs_cnt, rd_cnt, rd_first, rd_last, rd_bad;
        int vs_first, vs_cnt, fs_cnt, fs_t, blank_rd, lit, mism;
        reset = 1'b1;
        for (int i = 0; i < 8192; i++) mem[i] = 16'h0000;
        mem[0] = 16'h0001;
        mem[1] = 16'h8000;
        @(posedge clk);
        #1 chk_en = 1'b1;
        repeat (4) @(posedge clk);
        @(negedge clk);
        chk("rst_rd_en", 32'(rd_en), 32'd0);
        chk("rst_pixel", 32'(pixel), 32'd0);
        chk("rst_de", 32'(de), 32'd0);
        chk("rst_hsync", 32'(hsync), 32'd1);
        chk("rst_vsync", 32'(vsync), 32'd1);
        @(posedge clk);
        #1 reset = 1'b0;

        wait_t(0);
        chk("first_rd_en", 32'(rd_en), 32'd1);
        chk("first_rd_addr", 32'(rd_addr), 32'd0);
        wait_t(1);
        chk("de_t1", 32'(de), 32'd0);
        wait_t(2);
        chk("de_t2", 32'(de), 32'd1);
        chk("fs_t2", 32'(frame_start), 32'd1);
        chk("pix_h0", 32'(pixel), 32'd1);

        hi_cnt = 0; hi_last = -1; hs_first = -1; hs_cnt = 0;
        for (int c = 3; c < 802; c++) begin
            wait_t(c);
            if (pixel === 1'b1) begin hi_cnt++; hi_last = c; end
            if (hsync === 1'b0) begin
                if (hs_first < 0) hs_first = c;
                hs_cnt++;
            end
        end
        chk("line0_lit_count", 32'(hi_cnt), 32'd1);
        chk("line0_lit_pos", 32'(hi_last), 32'd33);
        chk("hsync_start", 32'(hs_first), 32'd530);
        chk("hsync_width", 32'(hs_cnt), 32'd96);

        rd_cnt = 0; rd_first = -1; rd_last = -1; rd_bad = 0;
        for (int c = 802; c < 3200; c++) begin
            wait_t(c);
            if (c >= 2400 && rd_en === 1'b1) begin
                if (rd_first < 0) rd_first = int'(rd_addr);
                if (int'(rd_addr) != 96 + rd_cnt || (c - 2400) % 16 != 0) rd_bad++;
                rd_last = int'(rd_addr);
                rd_cnt++;
            end
        end
        chk("line3_reads", 32'(rd_cnt), 32'd32);
        chk("line3_first", 32'(rd_first), 32'd96);
        chk("line3_last", 32'(rd_last), 32'd127);
        chk("line3_order", 32'(rd_bad), 32'd0);

        vs_first = -1; vs_cnt = 0; fs_cnt = 0; fs_t = -1; blank_rd = 0;
        for (int c = 3200; c < 11203; c++) begin
            wait_t(c);
            if (vsync === 1'b0) begin
                if (vs_first < 0) vs_first = c;
                vs_cnt++;
            end
            if (frame_start === 1'b1) begin fs_cnt++; fs_t = c; end
            if (c >= 4800 && c < 11200 && rd_en !== 1'b0) blank_rd++;
        end
        chk("vsync_start", 32'(vs_first), 32'd7202);
        chk("vsync_width", 32'(vs_cnt), 32'd1600);
        chk("frame_start_period", 32'(fs_t), 32'd11202);
        chk("frame_start_count", 32'(fs_cnt), 32'd1);
        chk("vblank_reads", 32'(blank_rd), 32'd0);

        // All-lit screen: lit pixels must coincide exactly with de.
        @(posedge clk);
        #1 reset = 1'b1;
        @(posedge clk);
        #1 for (int i = 0; i < 8192; i++) mem[i] = 16'hFFFF;
        @(posedge clk);
        #1 reset = 1'b0;
        lit = 0; mism = 0;
        for (int c = 0; c < 11202; c++) begin
            wait_t(c);
            if (pixel === 1'b1) lit++;
            if (pixel !== de) mism++;
        end
        chk("blank_lit_count", 32'(lit), 32'd3072);
        chk("blank_pix_vs_de", 32'(mism), 32'd0);

        // Restart from a fresh frame, then reset mid-line at h=200, v=2.
        @(posedge clk);
        #1 reset = 1'b1;
        @(posedge clk);
        #1 reset = 1'b0;
        wait_t(1799);
        chk("pre_rst_pixel", 32'(pixel), 32'd1);
        @(posedge clk);
        #1 reset = 1'b1;
        @(posedge clk);
        #1 reset = 1'b0;
        wait_t(0);
        chk("mid_rst_pixel", 32'(pixel), 32'd0);
        chk("mid_rst_de", 32'(de), 32'd0);
        chk("mid_rst_hsync", 32'(hsync), 32'd1);
        chk("mid_rst_rd_en", 32'(rd_en), 32'd1);
        chk("mid_rst_rd_addr", 32'(rd_addr), 32'd0);
        wait_t(1);
        chk("mid_rst_fs_t1", 32'(frame_start), 32'd0);
        wait_t(2);
        chk("mid_rst_fs_t2", 32'(frame_start), 32'd1);
        chk("mid_rst_pix_t2", 32'(pixel), 32'd1);

        @(negedge clk);
        chk_en = 1'b0;
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #3_000_000;
        $display("FAIL watchdog t=%0d", t);
        $fatal(1, "watchdog expired");
    end
endmodule
